// File: rtl/ntt_stage_ctrl_pkg.sv
// Shared types and helpers for the NTT stage controller.
//   ctrl_state_e : controller FSM states
//   stage_mode_e : how this stage relates to the current ring length
//   classify_stage / pair_count_log2 : stage-mode and pair-count helpers
package ntt_stage_ctrl_pkg;

    // Width of the runtime log2 ring-length input.
    localparam int LEN_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN_A = 2'd1,
        RUN_B = 2'd2,
        DRAIN = 2'd3
    } ctrl_state_e;

    typedef enum logic [1:0] {
        NORMAL  = 2'd0,
        LEADING = 2'd1,
        BYPASS  = 2'd2
    } stage_mode_e;

    // A stage at or beyond the ring length only copies data through; the
    // stage just below it is the first one that really transforms.
    function automatic stage_mode_e classify_stage(input int stage_num, input int log2_len);
        stage_mode_e mode;
        if (stage_num >= log2_len) begin
            mode = BYPASS;
        end else if (stage_num == log2_len - 1) begin
            mode = LEADING;
        end else begin
            mode = NORMAL;
        end
        return mode;
    endfunction

    // log2 of the number of line pairs per polynomial.
    function automatic int pair_count_log2(input int log2_len, input int line_log2);
        return log2_len - line_log2 - 1;
    endfunction

endpackage

// File: rtl/ntt_ctrl_delay.sv
// Fixed-depth shift register that matches the butterfly pipeline latency.
//   clk, rst : clock, synchronous active-high clear of every stage
//   din      : word entering the pipeline
//   dout     : din delayed by exactly DEPTH cycles (registered)
module ntt_ctrl_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe_r [DEPTH];

    // Shift the word one stage per cycle; reset empties every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pipe_r[i] <= '0;
            end
        end else begin
            pipe_r[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign dout = pipe_r[DEPTH-1];

endmodule

// File: rtl/ntt_stage_ctrl.sv
// Address/control sequencer for one NTT stage over a two-polynomial ping-pong.
// Inputs : clk, rst (sync, active-high), log2_len, in_empty, out_full, rob_empty
// Outputs: in_addrA/in_addrB, poly_sel, bf_valid, bf_bypass, rou_addr (read side),
//          out_addrA/out_addrB, out_wen, out_poly_sel (write side, BF_LATENCY later),
//          in_rd_finish, out_wr_finish (completion pulses), busy.
module ntt_stage_ctrl
    import ntt_stage_ctrl_pkg::*;
#(
    parameter int LINE_SIZE    = 4,
    parameter int ADDR_WIDTH   = 9,
    parameter int STAGE_NUM    = 9,
    parameter int MAX_LOG2_LEN = 11,
    parameter int BF_LATENCY   = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_WIDTH-1:0]  log2_len,
    input  logic                  in_empty,
    input  logic                  out_full,
    input  logic                  rob_empty,
    output logic [ADDR_WIDTH-1:0] in_addrA,
    output logic [ADDR_WIDTH-1:0] in_addrB,
    output logic                  poly_sel,
    output logic                  bf_valid,
    output logic                  bf_bypass,
    output logic [ADDR_WIDTH-1:0] rou_addr,
    output logic [ADDR_WIDTH-1:0] out_addrA,
    output logic [ADDR_WIDTH-1:0] out_addrB,
    output logic                  out_wen,
    output logic                  out_poly_sel,
    output logic                  in_rd_finish,
    output logic                  out_wr_finish,
    output logic                  busy
);

    localparam int LINE_LOG2 = $clog2(LINE_SIZE);
    // Butterfly distance in lines for this stage.
    localparam int SL = STAGE_NUM - LINE_LOG2;
    localparam logic [ADDR_WIDTH-1:0] SL_STEP = ADDR_WIDTH'(32'd1 << SL);
    localparam logic [ADDR_WIDTH-1:0] SL_MASK = ADDR_WIDTH'((32'd1 << SL) - 32'd1);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    // Delay word: {last, poly_sel, bf_valid, in_addrB, in_addrA}
    localparam int DLY_W = 2 * ADDR_WIDTH + 3;

    ctrl_state_e            state_r, state_n;
    stage_mode_e            mode_r, mode_in_s;
    logic [ADDR_WIDTH-1:0]  j_r, j_n;
    logic [ADDR_WIDTH-1:0]  p_last_r, p_last_s;
    int                     pl2_s;
    logic                   start_s, issue_s, last_pair_s;
    logic [ADDR_WIDTH-1:0]  addr_a_s, addr_b_s, rou_s;
    logic [ADDR_WIDTH-1:0]  in_addr_a_r, in_addr_b_r, rou_addr_r;
    logic                   poly_sel_r, bf_valid_r, bf_bypass_r, last_r;
    logic                   in_rd_finish_r, out_wr_finish_r, busy_r;
    logic [DLY_W-1:0]       dly_in_s, dly_out_s;
    logic                   dly_last_s;

    // Start qualification and per-transaction constants derived from the live length input.
    always_comb begin
        mode_in_s = classify_stage(STAGE_NUM, int'(log2_len));
        pl2_s     = pair_count_log2(int'(log2_len), LINE_LOG2);
        if (pl2_s < 0) begin
            p_last_s = '0;
        end else begin
            p_last_s = ADDR_WIDTH'((32'd1 << pl2_s) - 32'd1);
        end
        // The leading stage must also wait for reorder-buffer work.
        start_s = !in_empty && !out_full && ((mode_in_s != LEADING) || !rob_empty);
    end

    // Read-side address generation for the current pair index.
    always_comb begin
        issue_s     = (state_r == RUN_A) || (state_r == RUN_B);
        last_pair_s = (j_r == p_last_r);
        if (mode_r == BYPASS) begin
            addr_a_s = {j_r[ADDR_WIDTH-2:0], 1'b0};
            addr_b_s = {j_r[ADDR_WIDTH-2:0], 1'b1};
            rou_s    = '0;
        end else begin
            // Insert a zero at bit SL: pairs are (block base + offset, +2^SL).
            addr_a_s = ((j_r >> SL) << (SL + 1)) | (j_r & SL_MASK);
            addr_b_s = addr_a_s + SL_STEP;
            rou_s    = j_r & SL_MASK;
        end
    end

    // Next-state and pair-counter logic.
    always_comb begin
        state_n = state_r;
        j_n     = j_r;
        case (state_r)
            IDLE: begin
                j_n = '0;
                if (start_s) begin
                    state_n = RUN_A;
                end else begin
                    state_n = IDLE;
                end
            end
            RUN_A: begin
                if (last_pair_s) begin
                    state_n = RUN_B;
                    j_n     = '0;
                end else begin
                    j_n = j_r + ONE_A;
                end
            end
            RUN_B: begin
                if (last_pair_s) begin
                    state_n = DRAIN;
                    j_n     = '0;
                end else begin
                    j_n = j_r + ONE_A;
                end
            end
            DRAIN: begin
                // Leave as the final write emerges, so IDLE coincides with out_wr_finish.
                if (dly_last_s) begin
                    state_n = IDLE;
                end else begin
                    state_n = DRAIN;
                end
            end
            default: begin
                state_n = IDLE;
                j_n     = '0;
            end
        endcase
    end

    // State, counter and per-transaction latches (length is frozen on IDLE exit).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            j_r      <= '0;
            mode_r   <= NORMAL;
            p_last_r <= '0;
        end else begin
            state_r <= state_n;
            j_r     <= j_n;
            if ((state_r == IDLE) && start_s) begin
                mode_r   <= mode_in_s;
                p_last_r <= p_last_s;
            end
        end
    end

    // Registered read-side outputs and completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_addr_a_r     <= '0;
            in_addr_b_r     <= '0;
            rou_addr_r      <= '0;
            poly_sel_r      <= 1'b0;
            bf_valid_r      <= 1'b0;
            bf_bypass_r     <= 1'b0;
            last_r          <= 1'b0;
            in_rd_finish_r  <= 1'b0;
            out_wr_finish_r <= 1'b0;
            busy_r          <= 1'b0;
        end else begin
            in_addr_a_r     <= issue_s ? addr_a_s : '0;
            in_addr_b_r     <= issue_s ? addr_b_s : '0;
            rou_addr_r      <= issue_s ? rou_s : '0;
            poly_sel_r      <= (state_r == RUN_B);
            bf_valid_r      <= issue_s;
            bf_bypass_r     <= issue_s && (mode_r == BYPASS);
            last_r          <= (state_r == RUN_B) && last_pair_s;
            in_rd_finish_r  <= last_r;
            out_wr_finish_r <= dly_last_s;
            busy_r          <= (state_n != IDLE);
        end
    end

    assign dly_in_s = {last_r, poly_sel_r, bf_valid_r, in_addr_b_r, in_addr_a_r};

    ntt_ctrl_delay #(
        .WIDTH (DLY_W),
        .DEPTH (BF_LATENCY)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (dly_in_s),
        .dout (dly_out_s)
    );

    assign dly_last_s    = dly_out_s[DLY_W-1];
    assign out_poly_sel  = dly_out_s[DLY_W-2];
    assign out_wen       = dly_out_s[DLY_W-3];
    assign out_addrB     = dly_out_s[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign out_addrA     = dly_out_s[ADDR_WIDTH-1:0];

    assign in_addrA      = in_addr_a_r;
    assign in_addrB      = in_addr_b_r;
    assign rou_addr      = rou_addr_r;
    assign poly_sel      = poly_sel_r;
    assign bf_valid      = bf_valid_r;
    assign bf_bypass     = bf_bypass_r;
    assign in_rd_finish  = in_rd_finish_r;
    assign out_wr_finish = out_wr_finish_r;
    assign busy          = busy_r;

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Scoreboard bench for ntt_stage_ctrl: a driver pushes the expected read and
// write pair streams computed from the stage's butterfly geometry; a monitor
// pops and compares whenever bf_valid / out_wen are seen.
module tb_ntt_stage_ctrl;

    localparam int LINE_SIZE    = 4;
    localparam int ADDR_WIDTH   = 9;
    localparam int STAGE_NUM    = 9;
    localparam int MAX_LOG2_LEN = 11;
    localparam int BF_LATENCY   = 6;

    typedef struct packed {
        logic                  poly;
        logic                  byp;
        logic [ADDR_WIDTH-1:0] rou;
        logic [ADDR_WIDTH-1:0] b;
        logic [ADDR_WIDTH-1:0] a;
    } rd_t;

    typedef struct packed {
        logic                  poly;
        logic [ADDR_WIDTH-1:0] b;
        logic [ADDR_WIDTH-1:0] a;
    } wr_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [3:0]            log2_len;
    logic                  in_empty, out_full, rob_empty;
    logic [ADDR_WIDTH-1:0] in_addrA, in_addrB, rou_addr, out_addrA, out_addrB;
    logic                  poly_sel, bf_valid, bf_bypass, out_wen, out_poly_sel;
    logic                  in_rd_finish, out_wr_finish, busy;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  rd_seen = 0, wr_seen = 0, rdfin_seen = 0, wrfin_seen = 0;
    bit  mon_en = 1'b0;
    rd_t rd_q[$];
    wr_t wr_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ntt_stage_ctrl #(
        .LINE_SIZE    (LINE_SIZE),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .STAGE_NUM    (STAGE_NUM),
        .MAX_LOG2_LEN (MAX_LOG2_LEN),
        .BF_LATENCY   (BF_LATENCY)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .log2_len      (log2_len),
        .in_empty      (in_empty),
        .out_full      (out_full),
        .rob_empty     (rob_empty),
        .in_addrA      (in_addrA),
        .in_addrB      (in_addrB),
        .poly_sel      (poly_sel),
        .bf_valid      (bf_valid),
        .bf_bypass     (bf_bypass),
        .rou_addr      (rou_addr),
        .out_addrA     (out_addrA),
        .out_addrB     (out_addrB),
        .out_wen       (out_wen),
        .out_poly_sel  (out_poly_sel),
        .in_rd_finish  (in_rd_finish),
        .out_wr_finish (out_wr_finish),
        .busy          (busy)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a stage of distance `span` lines pairs every line whose
    // span-block index is even with the line span above it, in line order.
    // Stages at or past the ring length just stream consecutive line pairs.
    task automatic push_expected(input int len);
        int lines = (1 << len) / LINE_SIZE;
        int span  = (1 << STAGE_NUM) / LINE_SIZE;
        rd_t r;
        wr_t w;
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < lines; a++) begin
                if (STAGE_NUM >= len) begin
                    if (a % 2 == 0) begin
                        r = '{poly: p[0], byp: 1'b1, rou: '0,
                              b: ADDR_WIDTH'(a + 1), a: ADDR_WIDTH'(a)};
                        rd_q.push_back(r);
                    end
                end else if ((a / span) % 2 == 0) begin
                    r = '{poly: p[0], byp: 1'b0, rou: ADDR_WIDTH'(a % span),
                          b: ADDR_WIDTH'(a + span), a: ADDR_WIDTH'(a)};
                    rd_q.push_back(r);
                end
                if (rd_q.size() > 0 && rd_q[rd_q.size()-1].a == ADDR_WIDTH'(a)
                    && rd_q[rd_q.size()-1].poly == p[0]) begin
                    w = '{poly: p[0], b: rd_q[rd_q.size()-1].b, a: ADDR_WIDTH'(a)};
                    wr_q.push_back(w);
                end
            end
        end
    endtask

    // Monitor: compares every presented read pair and write-back against the scoreboard.
    initial begin
        rd_t act_r, exp_r;
        wr_t act_w, exp_w;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (bf_valid) begin
                    rd_seen++;
                    act_r = '{poly: poly_sel, byp: bf_bypass, rou: rou_addr, b: in_addrB, a: in_addrA};
                    if (rd_q.size() == 0) begin
                        check("rd_unexpected", longint'(act_r), -1);
                    end else begin
                        exp_r = rd_q.pop_front();
                        check("rd_pair", longint'(act_r), longint'(exp_r));
                    end
                end
                if (out_wen) begin
                    wr_seen++;
                    act_w = '{poly: out_poly_sel, b: out_addrB, a: out_addrA};
                    if (wr_q.size() == 0) begin
                        check("wr_unexpected", longint'(act_w), -1);
                    end else begin
                        exp_w = wr_q.pop_front();
                        check("wr_pair", longint'(act_w), longint'(exp_w));
                    end
                end
                if (in_rd_finish)  rdfin_seen++;
                if (out_wr_finish) wrfin_seen++;
            end
        end
    end

    function automatic longint all_outputs();
        return longint'({in_addrA, in_addrB, poly_sel, bf_valid, bf_bypass, rou_addr,
                         out_addrA, out_addrB, out_wen, out_poly_sel,
                         in_rd_finish, out_wr_finish, busy});
    endfunction

    // Waits for busy with a cycle bound; reports whether it arrived.
    task automatic wait_busy(output bit got);
        got = 1'b0;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge clk);
            if (busy) got = 1'b1;
        end
    endtask

    // One full transaction at length len; log2_len switches to new_len during RUN_A.
    task automatic run_txn(input int len, input int new_len);
        int  p = (1 << len) / LINE_SIZE / 2;
        int  hold, t0, t_rd, t_fin, rd0, wr0, rf0, wf0;
        bit  got, done, leading, saw_busy;
        leading = (STAGE_NUM == len - 1);
        log2_len = 4'(len);
        // Output-full backpressure must hold the controller in IDLE.
        hold = $urandom_range(0, 4);
        if (hold > 0) begin
            saw_busy = 1'b0;
            out_full = 1'b1; in_empty = 1'b0; rob_empty = 1'b0;
            repeat (hold) begin
                @(negedge clk);
                if (busy) saw_busy = 1'b1;
            end
            check("out_full_gates", saw_busy, 0);
        end
        push_expected(len);
        rd0 = rd_seen; wr0 = wr_seen; rf0 = rdfin_seen; wf0 = wrfin_seen;
        rob_empty = leading ? 1'b0 : 1'($urandom_range(0, 1));
        out_full  = 1'b0;
        in_empty  = 1'b0;
        wait_busy(got);
        check("start", got, 1);
        t0 = cyc;
        in_empty  = 1'b1;
        rob_empty = 1'($urandom_range(0, 1));
        out_full  = 1'($urandom_range(0, 1));
        t_rd = -1; t_fin = -1; done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            if (k == 5) log2_len = 4'(new_len);
            @(negedge clk);
            if (in_rd_finish && t_rd < 0) t_rd = cyc - t0;
            if (out_wr_finish) begin
                t_fin = cyc - t0;
                done  = 1'b1;
                check("busy_low_at_finish", busy, 0);
            end
        end
        check("rd_finish_latency", t_rd, 2 * p + 1);
        check("wr_finish_latency", t_fin, 2 * p + BF_LATENCY + 1);
        check("bf_valid_count", rd_seen - rd0, 2 * p);
        check("out_wen_count", wr_seen - wr0, 2 * p);
        check("rd_finish_pulses", rdfin_seen - rf0, 1);
        check("wr_finish_pulses", wrfin_seen - wf0, 1);
        check("rd_q_drained", rd_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        in_empty = 1'b1;
        out_full = 1'b0;
        rd_q.delete();
        wr_q.delete();
        repeat ($urandom_range(0, 3)) @(negedge clk);
    endtask

    initial begin
        bit saw_busy, hit, got;
        int rd0, wr0, rf0, wf0, npb;
        rst = 1'b1; log2_len = 4'd10; in_empty = 1'b1; out_full = 1'b0; rob_empty = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Leading stage with an empty ROB must not start.
        rd0 = rd_seen; saw_busy = 1'b0;
        in_empty = 1'b0; rob_empty = 1'b1; log2_len = 4'd10;
        repeat (20) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        check("rob_gate_busy", saw_busy, 0);
        check("rob_gate_valid", rd_seen - rd0, 0);
        in_empty = 1'b1;
        @(negedge clk);

        run_txn(10, 10);
        run_txn(11, 11);
        run_txn(9, 9);
        run_txn(10, 11);
        run_txn(11, 11);

        // Reset in the middle of RUN_B aborts cleanly.
        push_expected(10);
        log2_len = 4'd10; rob_empty = 1'b0; out_full = 1'b0; in_empty = 1'b0;
        wait_busy(got);
        check("abort_start", got, 1);
        in_empty = 1'b1;
        hit = 1'b0; npb = 0;
        for (int k = 0; k < 1000 && !hit; k++) begin
            @(negedge clk);
            if (bf_valid && poly_sel) begin
                npb++;
                if (npb == 51) hit = 1'b1;
            end
        end
        check("abort_pair50_seen", hit, 1);
        check("abort_pair50_addr", in_addrA, 50);
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort_outputs_zero", all_outputs(), 0);
        rst = 1'b0;
        rd_q.delete();
        wr_q.delete();
        rd0 = rd_seen; wr0 = wr_seen; rf0 = rdfin_seen; wf0 = wrfin_seen;
        mon_en = 1'b1;
        repeat (30) @(negedge clk);
        check("abort_no_wen", wr_seen - wr0, 0);
        check("abort_no_valid", rd_seen - rd0, 0);
        check("abort_no_rd_finish", rdfin_seen - rf0, 0);
        check("abort_no_wr_finish", wrfin_seen - wf0, 0);
        run_txn(10, 10);

        // Randomised lengths and inputs.
        for (int t = 0; t < 6; t++) begin
            int len = $urandom_range(9, 11);
            run_txn(len, $urandom_range(9, 11));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
